// File: rtl/y86_dmem_stage.sv
// ---------------------------------------------------------------------------
// y86_dmem_stage
//
// Multi-cycle data-memory stage for the sequential Y86-64 core. The icode is
// decoded when a request is accepted and selects a read, a write or no
// access. Accesses are 8-byte, little-endian and may start at any byte.
// Valid accesses spend LATENCY cycles in BUSY before they touch the array.
// Range errors and non-memory ops skip BUSY and respond on the next cycle.
//
// Parameters
//   DEPTH    memory size in bytes (>= 8)
//   LATENCY  wait cycles in BUSY before the access (>= 1)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   start           request, sampled only while ready=1
//   icode           Y86 instruction code
//   valA            register operand (write data or read address)
//   valE            ALU result (address)
//   valP            next PC (write data for call)
//   ready           stage idle, able to accept start
//   done            one-cycle completion pulse
//   valM            read data (0 for writes, non-memory ops, errors)
//   dmem_error      last completed op addressed out of range
//   datamem         data moved by the last completed access
//   memory_address  effective address of the last accepted op
// ---------------------------------------------------------------------------
module y86_dmem_stage #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        ready,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [63:0] datamem,
    output logic [63:0] memory_address
);

    localparam int AW   = $clog2(DEPTH);
    localparam int ROWS = (DEPTH + 7) / 8;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Highest legal start address; the compare is a full 64-bit unsigned one
    // so huge addresses never alias into the array.
    localparam logic [63:0]   MAX_ADDR = 64'(DEPTH - 8);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Request decode (combinational, only consumed at accept)
    // ------------------------------------------------------------------
    logic        dec_mem;
    logic        dec_write;
    logic [63:0] dec_addr;
    logic [63:0] dec_wdata;
    logic        dec_range_err;

    always_comb begin
        dec_mem   = 1'b0;
        dec_write = 1'b0;
        dec_addr  = 64'd0;
        dec_wdata = 64'd0;
        case (icode)
            IC_RMMOVQ: begin
                dec_mem   = 1'b1;
                dec_write = 1'b1;
                dec_addr  = valE;
                dec_wdata = valA;
            end
            IC_MRMOVQ: begin
                dec_mem  = 1'b1;
                dec_addr = valE;
            end
            IC_CALL: begin
                dec_mem   = 1'b1;
                dec_write = 1'b1;
                dec_addr  = valE;
                dec_wdata = valP;
            end
            IC_RET: begin
                dec_mem  = 1'b1;
                dec_addr = valA;
            end
            IC_PUSHQ: begin
                dec_mem   = 1'b1;
                dec_write = 1'b1;
                dec_addr  = valE;
                dec_wdata = valA;
            end
            IC_POPQ: begin
                dec_mem  = 1'b1;
                dec_addr = valA;
            end
            default: begin
                dec_mem = 1'b0;
            end
        endcase
        dec_range_err = dec_mem && (dec_addr > MAX_ADDR);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_write_q, is_write_d;
    logic [AW-1:0] idx_q, idx_d;       // in-range byte address of the access
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   valm_q, valm_d;
    logic [63:0]   datamem_q, datamem_d;
    logic          err_q, err_d;
    logic [63:0]   maddr_q, maddr_d;

    logic          mem_we;
    logic [63:0]   rd_word;
    logic [7:0]    bank_rd [8];

    // ------------------------------------------------------------------
    // Byte-banked storage. Byte address b lives in bank b%8, row b/8, so an
    // unaligned 8-byte access touches every bank exactly once and each bank
    // stays a simple one-byte-wide RAM. The storage has no reset: contents
    // survive rst and only a completed, error-free write changes them.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bank
            logic [7:0]    bank_q [ROWS];
            logic [2:0]    lane;       // which byte of the word this bank holds
            logic [AW-1:0] byte_addr;
            logic [RW-1:0] row;

            assign lane      = 3'(gi) - idx_q[2:0];
            assign byte_addr = idx_q + AW'(lane);
            assign row       = RW'(byte_addr >> 3);
            assign bank_rd[gi] = bank_q[row];

            always_ff @(posedge clk) begin
                if (mem_we) begin
                    bank_q[row] <= wdata_q[{lane, 3'b000} +: 8];
                end
            end
        end
    endgenerate

    // Reassemble the little-endian word: byte k comes from bank (idx+k)%8.
    always_comb begin
        rd_word = 64'd0;
        for (int k = 0; k < 8; k++) begin
            rd_word[k*8 +: 8] = bank_rd[3'(k) + idx_q[2:0]];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 64'd0;
            valm_q     <= 64'd0;
            datamem_q  <= 64'd0;
            err_q      <= 1'b0;
            maddr_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            valm_q     <= valm_d;
            datamem_q  <= datamem_d;
            err_q      <= err_d;
            maddr_q    <= maddr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        valm_d     = valm_q;
        datamem_d  = datamem_q;
        err_d      = err_q;
        maddr_d    = maddr_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Everything the access needs is captured here, so the
                    // inputs are free to change while BUSY.
                    is_write_d = dec_write;
                    idx_d      = dec_addr[AW-1:0];
                    wdata_d    = dec_wdata;
                    maddr_d    = dec_mem ? dec_addr : 64'd0;
                    if (dec_mem && !dec_range_err) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        // No access: results are known immediately.
                        state_d   = S_RESP;
                        valm_d    = 64'd0;
                        datamem_d = 64'd0;
                        err_d     = dec_range_err;
                    end
                end
            end

            S_BUSY: begin
                if (cnt_q == '0) begin
                    mem_we    = is_write_q;
                    valm_d    = is_write_q ? 64'd0 : rd_word;
                    datamem_d = is_write_q ? wdata_q : rd_word;
                    err_d     = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready          = (state_q == S_IDLE);
    assign done           = (state_q == S_RESP);
    assign valM           = valm_q;
    assign dmem_error     = err_q;
    assign datamem        = datamem_q;
    assign memory_address = maddr_q;

endmodule
